// File: rtl/microwave_pkg.sv
// Shared types and width helpers for the microwave timer controller.
package microwave_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OPEN  = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    BELL  = 3'd4
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a power-level field able to hold 0..levels.
  function automatic int pwr_w(input int levels);
    return $clog2(levels + 1);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
module tick_prescaler
  import microwave_pkg::*;
#(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = cnt_w(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign tick = en & (cnt == LAST);

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave controller: door interlock, countdown, power duty cycling, pause/resume, bell.
module microwave_timer_ctrl
  import microwave_pkg::*;
#(
  parameter  int TIME_W     = 8,
  parameter  int TICK_DIV   = 1000,
  parameter  int PWR_LEVELS = 4,
  parameter  int BELL_TICKS = 3,
  localparam int PWR_W      = pwr_w(PWR_LEVELS)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              door,
  input  logic              start,
  input  logic              cancel,
  input  logic [TIME_W-1:0] time_in,
  input  logic [PWR_W-1:0]  pwr_in,
  output logic              heat,
  output logic              light,
  output logic              bell,
  output logic [TIME_W-1:0] remaining,
  output logic [2:0]        state_o
);

  localparam int PH_W = cnt_w(PWR_LEVELS);
  localparam int BC_W = cnt_w(BELL_TICKS);

  state_t state, nxt;
  logic [PWR_W-1:0] pwr_q;
  logic [PH_W-1:0]  phase;
  logic [BC_W-1:0]  bell_cnt;
  logic             tick, start_ok, bell_done, load, cook_tick, abort;

  assign start_ok  = start & ~door & (time_in != '0) & (pwr_in != '0) &
                     (pwr_in <= PWR_W'(PWR_LEVELS));
  assign bell_done = tick & (bell_cnt == BC_W'(BELL_TICKS - 1));
  assign load      = (state == IDLE) & (nxt == COOK);
  assign cook_tick = (state == COOK) & ~door & ~cancel & tick;
  assign abort     = ((state == COOK) & ~door & cancel) | ((state == PAUSE) & cancel);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk  (clk),
    .nrst (nrst),
    .en   ((state == COOK) | (state == BELL)),
    .clr  (load | ((state == COOK) & (nxt == BELL))),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= nxt;
  end

  // Priority within each state: door > cancel > start > tick.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (door) nxt = OPEN;
             else if (start_ok) nxt = COOK;
      OPEN:  if (!door) nxt = IDLE;
      COOK:  if (door) nxt = PAUSE;
             else if (cancel) nxt = IDLE;
             else if (tick && remaining == TIME_W'(1)) nxt = BELL;
      PAUSE: if (cancel) nxt = door ? OPEN : IDLE;
             else if (start && !door) nxt = COOK;
      BELL:  if (door) nxt = OPEN;
             else if (cancel || bell_done) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    heat  = 1'b0;
    light = 1'b0;
    bell  = 1'b0;
    case (state)
      OPEN:  light = 1'b1;
      COOK:  begin
               light = 1'b1;
               heat  = PWR_W'(phase) < pwr_q;
             end
      PAUSE: light = 1'b1;
      BELL:  bell  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      remaining <= '0;
      pwr_q     <= '0;
      phase     <= '0;
      bell_cnt  <= '0;
    end else begin
      if (load) begin
        remaining <= time_in;
        pwr_q     <= pwr_in;
        phase     <= '0;
      end else if (abort) begin
        remaining <= '0;
      end else if (cook_tick) begin
        if (remaining != '0) remaining <= remaining - 1'b1;
        phase <= (phase == PH_W'(PWR_LEVELS - 1)) ? '0 : phase + 1'b1;
      end
      // Bell counter only lives inside BELL, so every entry starts from zero.
      if (state != BELL)     bell_cnt <= '0;
      else if (bell_done)    bell_cnt <= '0;
      else if (tick)         bell_cnt <= bell_cnt + 1'b1;
    end
  end

  assign state_o = state;

endmodule
